// File: rtl/bpu_update_ctrl.sv
// Branch predictor update sequencer: buffers MEM-stage resolutions, serializes BHT/PHT
// read-modify-write, and owns the table clear sweep after reset and flush.
module bpu_update_ctrl #(
  parameter int unsigned BHT_DEPTH  = 10,
  parameter int unsigned PHT_DEPTH  = 6,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 upd_valid_i,
  input  logic [31:0]          upd_pc_i,
  input  logic                 upd_taken_i,
  input  logic                 flush_req_i,
  output logic [BHT_DEPTH-1:0] bht_raddr_o,
  input  logic [PHT_DEPTH-1:0] bht_rdata_i,
  output logic                 bht_we_o,
  output logic [BHT_DEPTH-1:0] bht_waddr_o,
  output logic [PHT_DEPTH-1:0] bht_wdata_o,
  output logic [PHT_DEPTH-1:0] pht_raddr_o,
  input  logic [1:0]           pht_rdata_i,
  output logic                 pht_we_o,
  output logic [PHT_DEPTH-1:0] pht_waddr_o,
  output logic [1:0]           pht_wdata_o,
  output logic                 pred_valid_o,
  output logic [15:0]          drop_cnt_o
);

  localparam int unsigned PtrW       = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW       = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PhtEntries = 2 ** PHT_DEPTH;

  typedef enum logic [1:0] {
    StClr,
    StLook,
    StWr
  } state_e;

  state_e               state_q, state_d;
  logic [BHT_DEPTH-1:0] idx_q, idx_d;
  logic [PHT_DEPTH-1:0] hist_q, hist_d;

  // Each FIFO entry holds the BHT index and the resolved direction.
  logic [BHT_DEPTH:0]   fifo_q [FIFO_DEPTH];
  logic [PtrW-1:0]      wptr_q, rptr_q;
  logic [CntW-1:0]      cnt_q;
  logic [15:0]          drop_q;

  logic                 fifo_empty, fifo_full;
  logic                 push_req, push, pop, drop;
  logic [BHT_DEPTH-1:0] upd_idx;
  logic [BHT_DEPTH-1:0] head_idx;
  logic                 head_tkn;
  logic [1:0]           ctr_nxt;
  logic                 unused_pc;

  assign upd_idx   = upd_pc_i[BHT_DEPTH+1:2];
  assign unused_pc = ^{upd_pc_i[31:BHT_DEPTH+2], upd_pc_i[1:0]};

  assign head_idx = fifo_q[rptr_q][BHT_DEPTH:1];
  assign head_tkn = fifo_q[rptr_q][0];

  assign fifo_empty = (cnt_q == '0);
  assign fifo_full  = (cnt_q == CntW'(FIFO_DEPTH));

  // A full FIFO still accepts when the head retires in the same cycle.
  assign pop      = (state_q == StWr) && !flush_req_i;
  assign push_req = upd_valid_i && (state_q != StClr) && !flush_req_i;
  assign push     = push_req && (!fifo_full || pop);
  assign drop     = push_req && fifo_full && !pop;

  always_comb begin
    ctr_nxt = pht_rdata_i;
    if (head_tkn) begin
      if (pht_rdata_i != 2'b11) ctr_nxt = pht_rdata_i + 2'd1;
    end else begin
      if (pht_rdata_i != 2'b00) ctr_nxt = pht_rdata_i - 2'd1;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    hist_d      = hist_q;
    bht_raddr_o = head_idx;
    bht_we_o    = 1'b0;
    bht_waddr_o = head_idx;
    bht_wdata_o = '0;
    pht_raddr_o = hist_q;
    pht_we_o    = 1'b0;
    pht_waddr_o = hist_q;
    pht_wdata_o = ctr_nxt;

    unique case (state_q)
      StClr: begin
        bht_we_o    = 1'b1;
        bht_waddr_o = idx_q;
        bht_wdata_o = '0;
        if (32'(idx_q) < PhtEntries) begin
          pht_we_o    = 1'b1;
          pht_waddr_o = idx_q[PHT_DEPTH-1:0];
          pht_wdata_o = 2'b10;
        end
        idx_d = idx_q + BHT_DEPTH'(1);
        if (idx_q == '1) state_d = StLook;
      end
      StLook: begin
        if (!fifo_empty) begin
          hist_d  = bht_rdata_i;
          state_d = StWr;
        end
      end
      StWr: begin
        bht_we_o    = 1'b1;
        bht_wdata_o = {hist_q[PHT_DEPTH-2:0], head_tkn};
        pht_we_o    = 1'b1;
        state_d     = StLook;
      end
      default: state_d = StClr;
    endcase

    if (flush_req_i) begin
      bht_we_o = 1'b0;
      pht_we_o = 1'b0;
      state_d  = StClr;
      idx_d    = '0;
    end

    // Reset must silence the table ports before the clock edge arrives.
    if (!rst_ni) begin
      bht_we_o = 1'b0;
      pht_we_o = 1'b0;
    end
  end

  assign pred_valid_o = rst_ni && (state_q != StClr);
  assign drop_cnt_o   = drop_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StClr;
      idx_q   <= '0;
      hist_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      hist_q  <= hist_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else if (flush_req_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + PtrW'(1);
      if (pop) rptr_q <= rptr_q + PtrW'(1);
      if (push && !pop) begin
        cnt_q <= cnt_q + CntW'(1);
      end else if (pop && !push) begin
        cnt_q <= cnt_q - CntW'(1);
      end
    end
  end

  // Storage needs no reset: occupancy is tracked by cnt_q.
  always_ff @(posedge clk_i) begin
    if (push) fifo_q[wptr_q] <= {upd_idx, upd_taken_i};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      drop_q <= '0;
    end else if (drop && (drop_q != 16'hFFFF)) begin
      drop_q <= drop_q + 16'd1;
    end
  end

endmodule

// File: doc/bpu_update_ctrl.md
# bpu_update_ctrl

Sequencer for the branch predictor tables (BHT of per-PC 6-bit local histories, PHT of 2-bit saturating counters). It accepts branch resolutions from the MEM stage and buffers them in a small FIFO. Each update is serialized into a two-cycle read-modify-write of BHT then PHT. The block also owns the table clear sweep after reset and on `flush_req`, and tells fetch when predictions are valid. The tables are plain arrays outside this block, with combinational read ports and synchronous write ports.

## Interface
- `BHT_DEPTH`, 10: BHT index width; BHT has 2^BHT_DEPTH entries, indexed by pc[BHT_DEPTH+1:2].
- `PHT_DEPTH`, 6: history width and PHT index width; PHT has 2^PHT_DEPTH entries.
- `FIFO_DEPTH`, 4: update FIFO entries (power of two, ≥2).
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `upd_valid`  in  1  MEM-stage branch resolved this cycle (branchM).
- `upd_pc`  in  32  PC of the resolved branch (pcM).
- `upd_taken`  in  1  actual outcome (actual_takeM).
- `flush_req`  in  1  single-cycle request to clear both tables.
- `bht_raddr`  out  BHT_DEPTH  BHT read address.
- `bht_rdata`  in  PHT_DEPTH  BHT read data, combinational from `bht_raddr`.
- `bht_we`, `bht_waddr`, `bht_wdata`  out  1/BHT_DEPTH/PHT_DEPTH  BHT write port.
- `pht_raddr`  out  PHT_DEPTH  PHT read address.
- `pht_rdata`  in  2  PHT read data, combinational.
- `pht_we`, `pht_waddr`, `pht_wdata`  out  1/PHT_DEPTH/2  PHT write port.
- `pred_valid`  out  1  table contents usable; while low, fetch treats every prediction as not-taken.
- `drop_cnt`  out  16  updates lost to FIFO overflow; saturates at 0xFFFF.

## Operation
- FSM states:
  - S_CLR: clear sweep.
  - S_LOOK: idle or BHT lookup.
  - S_WR: PHT read and both table writes.
- Reset (`rst` low):
  - state=S_CLR, sweep index=0, FIFO empty, `drop_cnt`=0.
  - `bht_we`=`pht_we`=0 and `pred_valid`=0, forced combinationally while `rst` is low.
- S_CLR:
  - Each cycle: `bht_we`=1, `bht_waddr`=idx, `bht_wdata`=0.
  - If idx < 2^PHT_DEPTH, also `pht_we`=1, `pht_waddr`=idx[PHT_DEPTH-1:0], `pht_wdata`=2'b10 (weakly taken).
  - idx increments each cycle. After idx = 2^BHT_DEPTH−1 the FSM moves to S_LOOK.
  - Incoming updates are ignored: no push, no drop count.
- S_LOOK:
  - `bht_raddr` = FIFO head pc[BHT_DEPTH+1:2].
  - If FIFO is non-empty: latch `hist` = `bht_rdata` and go to S_WR. Otherwise stay.
- S_WR:
  - `pht_raddr` = `hist`. New counter = `pht_rdata`+1 if taken, −1 if not-taken, saturating at 2'b11 and 2'b00.
  - Encoding: 00 strongly not-taken, 01 weakly not-taken, 10 weakly taken, 11 strongly taken. The prediction bit is counter[1].
  - Writes in the same cycle: `bht_we`=1 with `bht_wdata`={hist[PHT_DEPTH-2:0], taken}; `pht_we`=1 with `pht_waddr`=`hist`.
  - Pop the FIFO, go to S_LOOK.
- `pred_valid` = (state != S_CLR).
- FIFO push: `upd_valid` high, state ≠ S_CLR, and (not full, or a pop occurs in the same cycle). A push while full with no pop increments `drop_cnt`; the entry is lost.
- `flush_req` has priority in any state:
  - All table writes are suppressed in that cycle and the FIFO is emptied.
  - Next state is S_CLR with idx=0. This also applies during S_CLR, which restarts the sweep.
- Updates are applied strictly in FIFO (program) order.

## Timing
- All table writes land on the rising edge that ends the cycle in which the write enable is high.
- Write outputs are combinational from state and registers. A lookup in the cycle after a write therefore sees the new value, and no bypass is needed.
- Sweep: the first edge after `rst` rises writes idx 0. The sweep takes 2^BHT_DEPTH cycles (1024 by default). `pred_valid` rises in the cycle after the write of idx 1023.
- Update latency: when an update is pushed at edge e with the FSM idle, the BHT is read in cycle e→e+1 and both tables are written at edge e+2.
- Throughput: one update every 2 cycles.
- Asserting `rst` mid-operation immediately drops all write enables. After release the sweep restarts at idx 0.

## Test plan
- Reset release:
  - `pred_valid`=0 for 1024 cycles.
  - `bht_we` walks addresses 0..1023 with data 0. `pht_we` is high only for addresses 0..63, with data 2'b10.
  - `pred_valid`=1 afterwards.
- After the sweep, a single update pc=0x00000040, taken: BHT[16] becomes 6'b000001 and PHT[0] becomes 2'b11, both at the second edge after acceptance.
- Three not-taken updates at pc=0x00000040 from cleared tables: BHT[16] stays 0; PHT[0] goes 10→01→00→00.
- `upd_valid` high for 10 consecutive cycles from idle, with distinct PCs:
  - 8 updates are accepted and `drop_cnt`=2 (the 8th and 10th pushes are dropped).
  - Table writes for the 8 accepted updates occur in push order.
- `flush_req` asserted in an S_WR cycle with 2 entries queued:
  - No `bht_we`/`pht_we` in that cycle, the FIFO is emptied, and a 1024-cycle sweep follows with `pred_valid`=0.
- `rst` pulled low at sweep idx 500: `bht_we` drops to 0 at once; after release the sweep restarts at idx 0.
